configs_loader: RTL and testbench

- Parametrised, clocked successor to the level-sensitive config latch bank.
- Accepts a valid/ready stream of configuration words and writes them into NUM_WORDS flop-based config registers, starting at a programmable base word index.
- Drives the flattened config vector to the tile fabric and provides a combinational readback port for scan/debug.
- Sits between the tile config controller and the LUT/routing config inputs.

---
 rtl/configs_loader_if.sv | 25 ++
 rtl/configs_loader.sv | 146 ++++++++++++++
 tb/tb_configs_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/configs_loader_if.sv
// Load-stream interface for configs_loader: start request, word stream and status.
interface configs_loader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_words;
  logic [DATA_W-1:0] d_in;
  logic              d_valid;
  logic              d_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, base_addr, num_words, d_in, d_valid,
    input  d_ready, busy, done, err
  );

  modport slave (
    input  start, base_addr, num_words, d_in, d_valid,
    output d_ready, busy, done, err
  );
endinterface

// File: rtl/configs_loader.sv
// Clocked config register bank loaded from a valid/ready word stream at a programmable base.
// Optional trailing checksum word enabled by defining CONFIGS_LOADER_CHECKSUM_EN.
module configs_loader #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 21,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  configs_loader_if.slave             io,
  input  logic [ADDR_W-1:0]           io_rd_addr,
  output logic [DATA_W-1:0]           io_rd_data,
  output logic [DATA_W*NUM_WORDS-1:0] io_configs_out
);

  // Two extra bits so base + num can never wrap back into the legal range.
  localparam int unsigned EndW = ADDR_W + 2;

`ifdef CONFIGS_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
`endif

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
`ifdef CONFIGS_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  logic [DATA_W-1:0] words_q [NUM_WORDS];

  logic [EndW-1:0] end_w;
  logic            range_bad;
  logic            accept;

  assign end_w     = EndW'(io.base_addr) + EndW'(io.num_words);
  assign range_bad = (io.num_words == '0) || (end_w > EndW'(NUM_WORDS));
  assign accept    = (state_q == StLoad) && ready_q && io.d_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      rem_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CONFIGS_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (io.start) begin
            if (range_bad) begin
              err_q <= 1'b1;
            end else begin
              err_q   <= 1'b0;
              ptr_q   <= io.base_addr;
              rem_q   <= io.num_words;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= StLoad;
`ifdef CONFIGS_LOADER_CHECKSUM_EN
              csum_q  <= '0;
`endif
            end
          end
        end
        StLoad: begin
          if (accept) begin
            ptr_q <= ptr_q + 1'b1;
            rem_q <= rem_q - 1'b1;
`ifdef CONFIGS_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ io.d_in;
            if (rem_q == (ADDR_W+1)'(1)) begin
              state_q <= StCheck;
            end
`else
            if (rem_q == (ADDR_W+1)'(1)) begin
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
`endif
          end
        end
`ifdef CONFIGS_LOADER_CHECKSUM_EN
        StCheck: begin
          if (io.d_valid) begin
            if (io.d_in != csum_q) begin
              err_q <= 1'b1;
            end
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
`endif
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        words_q[i] <= '0;
      end
    end else if (accept) begin
      words_q[ptr_q] <= io.d_in;
    end
  end

  assign io.d_ready = ready_q;
  assign io.busy    = busy_q;
  assign io.done    = done_q;
  assign io.err     = err_q;

  for (genvar gi = 0; gi < int'(NUM_WORDS); gi++) begin : g_flat
    assign io_configs_out[DATA_W*gi +: DATA_W] = words_q[gi];
  end

  always_comb begin
    io_rd_data = '0;
    if (32'(io_rd_addr) < NUM_WORDS) begin
      io_rd_data = words_q[io_rd_addr];
    end
  end

endmodule

// File: tb/tb_configs_loader.sv
// Directed self-checking bench for configs_loader (works with or without the checksum macro).
module tb_configs_loader;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_WORDS = 21;
  localparam int unsigned ADDR_W    = 5;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic [ADDR_W-1:0]           rd_addr = '0;
  logic [DATA_W-1:0]           rd_data;
  logic [DATA_W*NUM_WORDS-1:0] cfg;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] tb_xor = '0;

  configs_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  configs_loader #(
    .DATA_W   (DATA_W),
    .NUM_WORDS(NUM_WORDS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io            (bus.slave),
    .io_rd_addr    (rd_addr),
    .io_rd_data    (rd_data),
    .io_configs_out(cfg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cfg_zero(input string tag);
    n_vec++;
    assert (cfg === '0) else begin
      n_err++;
      $error("FAIL %s: observed nonzero config expected all zero", tag);
    end
  endtask

  task automatic do_start(input logic [4:0] base, input logic [5:0] num);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.num_words = num;
    tick();
    bus.start = 1'b0;
    tb_xor    = '0;
  endtask

  task automatic send(input logic [31:0] d);
    bus.d_valid = 1'b1;
    bus.d_in    = d;
    tick();
    bus.d_valid = 1'b0;
    tb_xor      = tb_xor ^ d;
  endtask

  // With the checksum feature, the load ends with a correct checksum word.
  task automatic end_load();
`ifdef CONFIGS_LOADER_CHECKSUM_EN
    check("check_ready", 32'(bus.d_ready), 32'd1);
    send(tb_xor);
`endif
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    bus.d_in      = '0;
    bus.d_valid   = 1'b0;

    // Reset
    tick();
    tick();
    check_cfg_zero("reset_cfg");
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_ready", 32'(bus.d_ready), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    tick();

    // Full load, back-to-back stream
    check("idle_ready", 32'(bus.d_ready), 32'd0);
    do_start(5'd0, 6'd21);
    check("full_ready", 32'(bus.d_ready), 32'd1);
    check("full_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 21; i++) begin
      check("full_nodone", 32'(bus.done), 32'd0);
      send(32'h1000 + 32'(i));
    end
    end_load();
    check("full_done", 32'(bus.done), 32'd1);
    check("full_busy_done", 32'(bus.busy), 32'd0);
    check("full_ready_done", 32'(bus.d_ready), 32'd0);
    check("full_err", 32'(bus.err), 32'd0);
    tick();
    check("full_done_once", 32'(bus.done), 32'd0);
    check("full_busy_after", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 21; i++) begin
      check("full_word", cfg[32*i +: 32], 32'h1000 + 32'(i));
    end

    // Preload all ones, then partial load with gapped valid
    do_start(5'd0, 6'd21);
    for (int i = 0; i < 21; i++) send(32'hFFFF_FFFF);
    end_load();
    tick();
    do_start(5'd5, 6'd3);
    tick();
    check("part_stall_ready", 32'(bus.d_ready), 32'd1);
    send(32'hA);
    tick();
    tick();
    send(32'hB);
    tick();
    check("part_stall_nodone", 32'(bus.done), 32'd0);
    send(32'hC);
    end_load();
    check("part_done", 32'(bus.done), 32'd1);
    tick();
    check("part_w4", cfg[32*4 +: 32], 32'hFFFF_FFFF);
    check("part_w5", cfg[32*5 +: 32], 32'hA);
    check("part_w6", cfg[32*6 +: 32], 32'hB);
    check("part_w7", cfg[32*7 +: 32], 32'hC);
    check("part_w8", cfg[32*8 +: 32], 32'hFFFF_FFFF);
    check("part_w20", cfg[32*20 +: 32], 32'hFFFF_FFFF);
    rd_addr = 5'd6;
    #1;
    check("rd_6", rd_data, 32'hB);
    rd_addr = 5'd25;
    #1;
    check("rd_oob", rd_data, 32'h0);
    rd_addr = 5'd20;
    #1;
    check("rd_20", rd_data, 32'hFFFF_FFFF);

    // Range errors
    do_start(5'd20, 6'd2);
    check("range_err", 32'(bus.err), 32'd1);
    check("range_ready", 32'(bus.d_ready), 32'd0);
    check("range_busy", 32'(bus.busy), 32'd0);
    check("range_done", 32'(bus.done), 32'd0);
    tick();
    check("range_nodone", 32'(bus.done), 32'd0);
    check("range_err_sticky", 32'(bus.err), 32'd1);
    do_start(5'd31, 6'd40);
    check("wrap_err", 32'(bus.err), 32'd1);
    check("wrap_ready", 32'(bus.d_ready), 32'd0);
    do_start(5'd0, 6'd0);
    check("zero_ready", 32'(bus.d_ready), 32'd0);
    do_start(5'd0, 6'd1);
    check("clear_err", 32'(bus.err), 32'd0);
    check("clear_ready", 32'(bus.d_ready), 32'd1);
    send(32'h55);
    end_load();
    check("one_done", 32'(bus.done), 32'd1);
    tick();
    check("one_w0", cfg[31:0], 32'h55);
    check("one_w1", cfg[63:32], 32'h1001 ^ 32'h1001 ^ 32'hFFFF_FFFF);

    // Start while busy is ignored; exactly two words still complete the load
    do_start(5'd2, 6'd2);
    send(32'h21);
    bus.start     = 1'b1;
    bus.base_addr = 5'd10;
    bus.num_words = 6'd1;
    tick();
    bus.start = 1'b0;
    check("busy_start_busy", 32'(bus.busy), 32'd1);
    check("busy_start_err", 32'(bus.err), 32'd0);
    send(32'h22);
    end_load();
    check("busy_start_done", 32'(bus.done), 32'd1);
    tick();
    check("busy_w2", cfg[32*2 +: 32], 32'h21);
    check("busy_w3", cfg[32*3 +: 32], 32'h22);
    check("busy_w10", cfg[32*10 +: 32], 32'hFFFF_FFFF);

    // Reset mid-load
    do_start(5'd0, 6'd4);
    send(32'h31);
    send(32'h32);
    reset = 1'b0;
    tick();
    check_cfg_zero("midrst_cfg");
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_ready", 32'(bus.d_ready), 32'd0);
    reset = 1'b1;
    bus.d_valid = 1'b1;
    bus.d_in    = 32'h77;
    tick();
    tick();
    bus.d_valid = 1'b0;
    check("midrst_idle_ready", 32'(bus.d_ready), 32'd0);
    check("midrst_no_write", cfg[31:0], 32'h0);

`ifdef CONFIGS_LOADER_CHECKSUM_EN
    do_start(5'd0, 6'd2);
    send(32'h0F0F_0F0F);
    send(32'hF0F0_F0F0);
    check("cs_ready", 32'(bus.d_ready), 32'd1);
    check("cs_busy", 32'(bus.busy), 32'd1);
    send(32'hFFFF_FFFF);
    check("cs_ok_done", 32'(bus.done), 32'd1);
    check("cs_ok_err", 32'(bus.err), 32'd0);
    tick();
    do_start(5'd0, 6'd2);
    send(32'h0F0F_0F0F);
    send(32'hF0F0_F0F0);
    send(32'h0);
    check("cs_bad_done", 32'(bus.done), 32'd1);
    check("cs_bad_err", 32'(bus.err), 32'd1);
    tick();
    check("cs_bad_w0", cfg[31:0], 32'h0F0F_0F0F);
    check("cs_bad_w1", cfg[63:32], 32'hF0F0_F0F0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
